// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller: one full adder processes the operands
// LSB-first over WIDTH cycles, with a valid/ready request and result handshake.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // Low WIDTH-1 result bits accumulate here; the last bit joins them at DONE.
    logic [WIDTH-2:0] part_q, part_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Full adder from two half-adder stages.
    logic ha1_s, ha1_c, ha2_s, ha2_c, fa_s, fa_co;
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        ha1_s    = a_q[0] ^ b_q[0];
        ha1_c    = a_q[0] & b_q[0];
        ha2_s    = ha1_s ^ carry_q;
        ha2_c    = ha1_s & carry_q;
        fa_s     = ha2_s;
        fa_co    = ha1_c | ha2_c;
        sum_next = {fa_s, part_q};
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        part_d       = part_q;
        sum_out_d    = sum_out_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        unique case (state_q)
            StIdle: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    a_d     = a_in;
                    b_d     = sub ? ~b_in : b_in;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                part_d  = sum_next[WIDTH-1:1];
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    sum_out_d = sum_next;
                    cout_d    = fa_co;
                    // carry_q is the carry into the MSB on this step.
                    ovf_d     = carry_q ^ fa_co;
                    state_d   = StDone;
                end
            end
            StDone: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            part_q    <= '0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign sum_out = sum_out_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: expected results are queued at request
// time and compared when result_valid appears.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         sub;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         ovf;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t sb_q[$];
    exp_t last;
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .cin          (cin),
        .sub          (sub),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum_out      (sum_out),
        .cout         (cout),
        .ovf          (ovf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sb, input int hold);
        exp_t e;
        int   lat;
        int   busy_n;
        @(negedge clk);
        check_val("start_ready_idle", start_ready, 1);
        a_in = a; b_in = b; cin = ci; sub = sb; start_valid = 1'b1;
        sb_q.push_back(model(a, b, ci, sb));
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        busy_n = 0;
        while (!result_valid && lat < 4 * W) begin
            if (busy) busy_n++;
            check_val("hold_sum_in_run", sum_out, last.s);
            @(negedge clk);
            a_in = W'($urandom); b_in = W'($urandom);
            lat++;
        end
        if (!result_valid) begin
            check_val("result_timeout", 0, 1);
            void'(sb_q.pop_front());
            return;
        end
        check_val("latency", lat, W);
        check_val("busy_cycles", busy_n, W);
        e = sb_q.pop_front();
        check_val("sum", sum_out, e.s);
        check_val("cout", cout, e.c);
        check_val("ovf", ovf, e.o);
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_val("done_valid_held", result_valid, 1);
            check_val("done_no_ready", start_ready, 0);
            check_val("done_not_busy", busy, 0);
            check_val("done_sum_stable", {sum_out, cout, ovf}, {e.s, e.c, e.o});
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check_val("taken_valid_low", result_valid, 0);
        check_val("taken_idle_ready", start_ready, 1);
        check_val("idle_sum_hold", {sum_out, cout, ovf}, {e.s, e.c, e.o});
        last = e;
    endtask

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b0;
        a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        last = '0;
        #1;
        check_val("rst_sum", sum_out, 0);
        check_val("rst_flags", {cout, ovf, result_valid, busy, start_ready}, 5'b00001);
        #11 rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h10, 8'h20, 1'b1, 1'b1, 0);
        run_op(8'h7F, 8'h00, 1'b1, 1'b0, 5);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 1);
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), i % 3);
        end

        // Abort an operation mid-flight with an asynchronous reset.
        @(negedge clk);
        a_in = 8'h33; b_in = 8'h11; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("abort_sum", sum_out, 0);
        check_val("abort_flags", {cout, ovf, result_valid, busy, start_ready}, 5'b00001);
        last = '0;
        @(negedge clk);
        check_val("abort_no_result", result_valid, 0);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

        check_val("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
